// File: rtl/i2c_ram_pkg.sv
// Shared definitions for the I2C display RAM arbiter: FSM states, RAM select
// codes and the default clear character.
package i2c_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR,
    ST_FETCH,
    ST_FETCH_LAST
  } state_t;

  localparam int          ADDR_W         = 5;
  localparam logic [1:0]  RAM_SEL_MENU   = 2'd0;
  localparam logic [1:0]  RAM_SEL_REMOTE = 2'd1;
  localparam logic [1:0]  RAM_SEL_LOCAL  = 2'd2;
  localparam logic [7:0]  CLEAR_CHAR_DEF = 8'h20;

endpackage

// File: rtl/i2c_ram_addr_counter.sv
// Burst address counter: cleared while idle, counts up on enable and parks
// on the terminal address instead of wrapping.
module i2c_ram_addr_counter
  import i2c_ram_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST_ADDR);

endmodule

// File: rtl/i2c_ram_arbiter.sv
// Arbitrates the shared MultiRAM between editor writes, local-RAM clears and
// display page fetches; bursts run to completion once started.
module i2c_ram_arbiter
  import i2c_ram_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = CLEAR_CHAR_DEF,
  parameter int         RAM_DEPTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_req,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  output logic        clr_done,
  input  logic        fetch_req,
  input  logic [1:0]  fetch_sel,
  input  logic [4:0]  fetch_menu,
  output logic        fetch_valid,
  output logic [4:0]  fetch_idx,
  output logic [7:0]  fetch_data,
  output logic        fetch_done,
  output logic [1:0]  ram_sel,
  output logic [4:0]  ram_menu,
  output logic [4:0]  ram_add,
  output logic [7:0]  ram_din,
  output logic        ram_w,
  input  logic [7:0]  ram_dout,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_sel;
  logic [4:0]  r_menu;
  logic        r_fvalid;
  logic [4:0]  r_fidx;
  logic        r_fdone;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic [4:0]  w_cnt;
  logic        w_cnt_last;

  i2c_ram_addr_counter #(
    .DEPTH (RAM_DEPTH)
  ) u_addr_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  always_comb begin
    w_next    = r_state;
    ram_w     = 1'b0;
    ram_sel   = 2'd0;
    ram_add   = 5'd0;
    ram_din   = 8'd0;
    wr_ack    = 1'b0;
    clr_done  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (wr_req)         w_next = ST_WRITE;
        else if (clr_req)   w_next = ST_CLEAR;
        else if (fetch_req) w_next = ST_FETCH;
      end
      ST_WRITE: begin
        ram_w   = 1'b1;
        ram_sel = RAM_SEL_LOCAL;
        ram_add = wr_addr;
        ram_din = wr_data;
        wr_ack  = 1'b1;
        w_next  = ST_IDLE;
      end
      ST_CLEAR: begin
        ram_w    = 1'b1;
        ram_sel  = RAM_SEL_LOCAL;
        ram_add  = w_cnt;
        ram_din  = CLEAR_CHAR;
        w_cnt_en = 1'b1;
        if (w_cnt_last) begin
          clr_done = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ram_sel  = r_sel;
        ram_add  = w_cnt;
        w_cnt_en = 1'b1;
        if (w_cnt_last) w_next = ST_FETCH_LAST;
      end
      ST_FETCH_LAST: begin
        // No new address here: this cycle only returns the byte for the last one.
        ram_sel = r_sel;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= 2'd0;
      r_menu   <= 5'd0;
      r_fvalid <= 1'b0;
      r_fidx   <= 5'd0;
      r_fdone  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_FETCH) begin
        r_sel  <= fetch_sel;
        r_menu <= fetch_menu;
      end
      // Read beats trail the address by one cycle to match the RAM's output register.
      r_fvalid <= (r_state == ST_FETCH);
      r_fidx   <= (r_state == ST_FETCH) ? w_cnt : 5'd0;
      r_fdone  <= (r_state == ST_FETCH) && w_cnt_last;
    end
  end

  assign ram_menu    = r_menu;
  assign fetch_valid = r_fvalid;
  assign fetch_idx   = r_fidx;
  assign fetch_data  = r_fvalid ? ram_dout : 8'd0;
  assign fetch_done  = r_fdone;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Randomized bench for i2c_ram_arbiter: a cycle-trace reference model built
// from the service rules, plus a behavioural MultiRAM with 1-cycle read latency.
module tb_i2c_ram_arbiter;

  localparam int W = 39;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_req, clr_req, fetch_req;
  logic [4:0]  wr_addr, fetch_menu;
  logic [7:0]  wr_data;
  logic [1:0]  fetch_sel;
  logic        wr_ack, clr_done, fetch_valid, fetch_done, ram_w, busy;
  logic [4:0]  fetch_idx, ram_menu, ram_add;
  logic [7:0]  fetch_data, ram_din, ram_dout;
  logic [1:0]  ram_sel;

  always #5 clk = ~clk;

  i2c_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .clr_req     (clr_req),
    .clr_done    (clr_done),
    .fetch_req   (fetch_req),
    .fetch_sel   (fetch_sel),
    .fetch_menu  (fetch_menu),
    .fetch_valid (fetch_valid),
    .fetch_idx   (fetch_idx),
    .fetch_data  (fetch_data),
    .fetch_done  (fetch_done),
    .ram_sel     (ram_sel),
    .ram_menu    (ram_menu),
    .ram_add     (ram_add),
    .ram_din     (ram_din),
    .ram_w       (ram_w),
    .ram_dout    (ram_dout),
    .busy        (busy)
  );

  logic [W-1:0] obs;
  assign obs = {ram_w, ram_sel, ram_add, ram_din, ram_menu, wr_ack, clr_done, busy,
                fetch_valid, fetch_idx, fetch_data, fetch_done};

  // ---------------- MultiRAM environment ----------------
  logic [7:0] seed_loc[32];
  logic [7:0] remote_arr[32];
  logic [7:0] ram_local[32];
  logic       ram_load;

  function automatic logic [7:0] menu_byte(input logic [4:0] mn, input logic [4:0] a);
    return {mn[2:0] ^ 3'd3, a};
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 32; i++) ram_local[i] <= seed_loc[i];
    end else if (ram_w && ram_sel == 2'd2) begin
      ram_local[ram_add] <= ram_din;
    end
    case (ram_sel)
      2'd0:    ram_dout <= menu_byte(ram_menu, ram_add);
      2'd1:    ram_dout <= remote_arr[ram_add];
      2'd2:    ram_dout <= ram_local[ram_add];
      default: ram_dout <= 8'd0;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0]   ref_local[32];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [1:0]   ph_q[$];
  logic [W-1:0] m_all, m_nomenu, m_last;
  logic [4:0]   late_a;
  logic [7:0]   late_d;
  string        cur_tag;
  int           n_checks = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] pk(
    input logic w, input logic [1:0] sel, input logic [4:0] add, input logic [7:0] din,
    input logic [4:0] menu, input logic ack, input logic cd, input logic bz,
    input logic fv, input logic [4:0] fidx, input logic [7:0] fdata, input logic fd);
    return {w, sel, add, din, menu, ack, cd, bz, fv, fidx, fdata, fd};
  endfunction

  function automatic logic [7:0] ref_read(input logic [1:0] s, input logic [4:0] mn,
                                          input logic [4:0] a);
    case (s)
      2'd0:    return menu_byte(mn, a);
      2'd1:    return remote_arr[a];
      2'd2:    return ref_local[a];
      default: return 8'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] e, input logic [W-1:0] m, input logic [1:0] p);
    exp_q.push_back(e);
    msk_q.push_back(m);
    ph_q.push_back(p);
  endtask

  task automatic add_idle();
    push('0, m_nomenu, 2'd0);
  endtask

  task automatic add_write(input logic [4:0] a, input logic [7:0] d);
    push(pk(1'b1, 2'd2, a, d, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0), m_nomenu, 2'd0);
    ref_local[a] = d;
    add_idle();
  endtask

  task automatic add_clear(input int late_at);
    for (int i = 0; i < 32; i++)
      push(pk(1'b1, 2'd2, 5'(i), 8'h20, 5'd0, 1'b0, (i == 31), 1'b1, 1'b0, 5'd0, 8'd0, 1'b0),
           m_nomenu, (i == late_at) ? 2'd2 : 2'd0);
    for (int i = 0; i < 32; i++) ref_local[i] = 8'h20;
    add_idle();
  endtask

  task automatic add_fetch(input logic [1:0] s, input logic [4:0] mn, input int late_at);
    for (int k = 0; k < 32; k++) begin
      if (k == 0)
        push(pk(1'b0, s, 5'd0, 8'd0, mn, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0), m_all,
             (k == late_at) ? 2'd3 : 2'd1);
      else
        push(pk(1'b0, s, 5'(k), 8'd0, mn, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k - 1),
                ref_read(s, mn, 5'(k - 1)), 1'b0), m_all, (k == late_at) ? 2'd3 : 2'd1);
    end
    push(pk(1'b0, s, 5'd0, 8'd0, mn, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31,
            ref_read(s, mn, 5'd31), 1'b1), m_last, 2'd1);
    add_idle();
  endtask

  // Walks the expected trace one cycle at a time, acting as the requesters.
  task automatic run_queue();
    logic [W-1:0] e, m;
    logic [1:0]   p;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      p = ph_q.pop_front();
      check(cur_tag, obs & m, e & m);
      if (wr_ack)     wr_req = 1'b0;
      if (clr_done)   clr_req = 1'b0;
      if (fetch_done) fetch_req = 1'b0;
      if (p[0]) begin
        fetch_sel  = 2'($urandom_range(0, 2));
        fetch_menu = 5'($urandom);
      end
      if (p[1]) begin
        wr_req  = 1'b1;
        wr_addr = late_a;
        wr_data = late_d;
      end
    end
    wr_req = 1'b0; clr_req = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic scen(input string tag, input bit dw, input bit dc, input bit df, input bit lw,
                      input logic [4:0] a, input logic [7:0] d,
                      input logic [1:0] s, input logic [4:0] mn);
    cur_tag = tag;
    late_a  = 5'($urandom);
    late_d  = 8'($urandom);
    if (dw) add_write(a, d);
    if (dc) begin
      add_clear(lw ? 5 : -1);
      if (lw) add_write(late_a, late_d);
    end
    if (df) begin
      add_fetch(s, mn, (lw && !dc) ? 5 : -1);
      if (lw && !dc) add_write(late_a, late_d);
    end
    wr_req = dw; wr_addr = a; wr_data = d;
    clr_req = dc;
    fetch_req = df; fetch_sel = s; fetch_menu = mn;
    run_queue();
    @(negedge clk);
    check({tag, "_gap"}, W'(busy), W'(0));
  endtask

  initial begin
    bit found;
    bit dw, dc, df, lw;
    m_all    = '1;
    m_nomenu = ~pk(1'b0, 2'd0, 5'd0, 8'd0, 5'h1f, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    m_last   = ~pk(1'b0, 2'd0, 5'h1f, 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      seed_loc[i]   = 8'($urandom);
      remote_arr[i] = 8'($urandom);
      ref_local[i]  = seed_loc[i];
    end
    ram_load = 1'b1;
    wr_req = 1'b1; clr_req = 1'b1; fetch_req = 1'b1;
    wr_addr = 5'd9; wr_data = 8'h5a; fetch_sel = 2'd1; fetch_menu = 5'd4;
    repeat (3) @(negedge clk);
    check("reset_outputs", obs, '0);
    ram_load = 1'b0;
    wr_req = 1'b0; clr_req = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", obs, '0);

    scen("write_5_41",  1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 8'h41, 2'd2, 5'd0);
    scen("clear",       1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 2'd2, 5'd0);
    scen("fetch_menu3", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 2'd0, 5'd3);
    scen("all_three",   1'b1, 1'b1, 1'b1, 1'b0, 5'd17, 8'h9c, 2'd2, 5'd1);
    scen("late_wr_fet", 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 8'd0, 2'd1, 5'd0);
    scen("late_wr_clr", 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 8'd0, 2'd2, 5'd6);

    // Reset in the middle of a fetch burst, request still held.
    cur_tag = "fetch_after_reset";
    fetch_req = 1'b1; fetch_sel = 2'd1; fetch_menu = 5'd7;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (fetch_valid && fetch_idx == 5'd10) found = 1'b1;
    end
    check("rst_wait_idx10", W'(found), W'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", obs, '0);
    repeat (2) @(negedge clk);
    check("rst_held_outputs", obs, '0);
    rst_n = 1'b1;
    add_fetch(2'd1, 5'd7, -1);
    run_queue();

    for (int n = 0; n < 20; n++) begin
      dw = 1'($urandom_range(0, 1));
      dc = 1'($urandom_range(0, 1));
      df = 1'($urandom_range(0, 1));
      lw = !dw && (dc || df) && ($urandom_range(0, 1) == 1);
      scen("random", dw, dc, df, lw, 5'($urandom), 8'($urandom),
           2'($urandom_range(0, 2)), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
